// File: rtl/t_ff_if.sv
// Control/data bus for the t_ff toggle flip-flop bank.
// The tff_set signal exists only when TFF_SYNC_SET_EN is defined.
interface t_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] tff_indata;
  logic             tff_clr;
  logic             tff_en;
`ifdef TFF_SYNC_SET_EN
  logic             tff_set;
`endif
  logic [WIDTH-1:0] tff_outdata;
  logic [WIDTH-1:0] tff_outdata_bar;

`ifdef TFF_SYNC_SET_EN
  modport master (
    output tff_indata, tff_clr, tff_en, tff_set,
    input  tff_outdata, tff_outdata_bar
  );

  modport slave (
    input  tff_indata, tff_clr, tff_en, tff_set,
    output tff_outdata, tff_outdata_bar
  );
`else
  modport master (
    output tff_indata, tff_clr, tff_en,
    input  tff_outdata, tff_outdata_bar
  );

  modport slave (
    input  tff_indata, tff_clr, tff_en,
    output tff_outdata, tff_outdata_bar
  );
`endif
endinterface

// File: rtl/t_ff.sv
// Bank of WIDTH independent T flip-flops with shared clear/enable and complementary outputs.
// Optional macro TFF_SYNC_SET_EN adds a synchronous set-to-all-ones below clear in priority.
module t_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic   clk,
  input  logic   reset,
  t_ff_if.slave  bus
);

  logic [WIDTH-1:0] q;

  // Priority: reset (async, active-low) > clear > set (optional) > enabled toggle > hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (bus.tff_clr) begin
      q <= '0;
    end
`ifdef TFF_SYNC_SET_EN
    else if (bus.tff_set) begin
      q <= '1;
    end
`endif
    else if (bus.tff_en) begin
      q <= q ^ bus.tff_indata;
    end
  end

  // Both outputs derive from the same register, so they can never disagree.
  assign bus.tff_outdata     = q;
  assign bus.tff_outdata_bar = ~q;

endmodule

// File: tb/tb_t_ff.sv
// Self-checking bench for t_ff: directed steps followed by randomized traffic
// compared against a rule-level reference model.
module tb_t_ff;

  localparam int           W     = 4;
  localparam logic [W-1:0] RST_V = '0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] model_q = RST_V;
`ifdef TFF_SYNC_SET_EN
  logic         set_drv = 1'b0;
`endif

  t_ff_if #(.WIDTH(W)) bus ();

  t_ff #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "/out"}, bus.tff_outdata, model_q);
    check_output({tag, "/bar"}, bus.tff_outdata_bar, ~model_q);
  endtask

  // Drive one cycle of inputs, advance the reference model at the edge, sample 1 time unit later.
  task automatic apply_stimulus(input logic clr, input logic en, input logic [W-1:0] t);
    logic set_now;
    set_now = 1'b0;
    bus.tff_clr    = clr;
    bus.tff_en     = en;
    bus.tff_indata = t;
`ifdef TFF_SYNC_SET_EN
    bus.tff_set = set_drv;
    set_now     = set_drv;
`endif
    @(posedge clk);
    if (!reset)       model_q = RST_V;
    else if (clr)     model_q = '0;
    else if (set_now) model_q = '1;
    else if (en)      model_q = model_q ^ t;
    #1;
  endtask

  task automatic step_expect(input string tag, input logic clr, input logic en,
                             input logic [W-1:0] t, input logic [W-1:0] exp);
    apply_stimulus(clr, en, t);
    check_output({tag, "/lit"}, bus.tff_outdata, exp);
    check_state(tag);
  endtask

  initial begin
    bus.tff_clr    = 1'b0;
    bus.tff_en     = 1'b1;
    bus.tff_indata = '1;
`ifdef TFF_SYNC_SET_EN
    bus.tff_set    = 1'b0;
`endif

    // Reset held low ignores toggling inputs across edges.
    #2;
    check_output("rst_async/out", bus.tff_outdata, 4'b0000);
    check_output("rst_async/bar", bus.tff_outdata_bar, 4'b1111);
    step_expect("rst_low_e1", 1'b0, 1'b1, 4'b1111, 4'b0000);
    step_expect("rst_low_e2", 1'b0, 1'b1, 4'b1111, 4'b0000);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step_expect("rst_hold", 1'b0, 1'b0, 4'b1111, 4'b0000);

    step_expect("tog_t1",  1'b0, 1'b1, 4'b1111, 4'b1111);
    step_expect("tog_t0",  1'b0, 1'b1, 4'b0000, 4'b1111);
    step_expect("tog_t1b", 1'b0, 1'b1, 4'b1111, 4'b0000);

    step_expect("clr_pre",  1'b0, 1'b1, 4'b1111, 4'b1111);
    step_expect("clr_en1",  1'b1, 1'b1, 4'b1111, 4'b0000);
    step_expect("clr_pre2", 1'b0, 1'b1, 4'b1111, 4'b1111);
    step_expect("clr_en0",  1'b1, 1'b0, 4'b1111, 4'b0000);

    for (int i = 0; i < 3; i++) step_expect("gate_hold0", 1'b0, 1'b0, 4'b1111, 4'b0000);
    step_expect("gate_tog1", 1'b0, 1'b1, 4'b1111, 4'b1111);
    for (int i = 0; i < 3; i++) step_expect("gate_hold1", 1'b0, 1'b0, 4'b1111, 4'b1111);
    step_expect("gate_tog0", 1'b0, 1'b1, 4'b1111, 4'b0000);
    step_expect("per_bit_a", 1'b0, 1'b1, 4'b0101, 4'b0101);
    step_expect("per_bit_b", 1'b0, 1'b1, 4'b1010, 4'b1111);

    // Reset asserted between edges must clear the outputs before the next edge.
    #2;
    reset   = 1'b0;
    model_q = RST_V;
    #1;
    check_output("rst_mid/out", bus.tff_outdata, 4'b0000);
    check_output("rst_mid/bar", bus.tff_outdata_bar, 4'b1111);
    step_expect("rst_mid_e1", 1'b0, 1'b1, 4'b1111, 4'b0000);
    step_expect("rst_mid_e2", 1'b0, 1'b1, 4'b1111, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    step_expect("post_rst", 1'b0, 1'b1, 4'b0011, 4'b0011);

`ifdef TFF_SYNC_SET_EN
    set_drv = 1'b1;
    step_expect("set_only", 1'b0, 1'b0, 4'b0000, 4'b1111);
    step_expect("set_tog",  1'b0, 1'b1, 4'b1111, 4'b1111);
    step_expect("clr_set",  1'b1, 1'b1, 4'b1111, 4'b0000);
    set_drv = 1'b0;
`endif

    for (int i = 0; i < 200; i++) begin
`ifdef TFF_SYNC_SET_EN
      set_drv = ($urandom_range(0, 7) == 0);
`endif
      apply_stimulus($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), W'($urandom));
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_ff.md
Name: t_ff

Overview:
- Clocked toggle flip-flop bank with synchronous clear, enable and complementary outputs.
- Used as a single-bit flag or control register in the basic-computer datapath, for example for sequence/state flags.
- Default configuration is 1 bit. Wider instances are per-bit independent T flip-flops that share control.

Parameters:
- WIDTH, 1, number of independent T flip-flop bits; must be >= 1.
- RESET_VAL, 0 (WIDTH bits), value loaded into tff_outdata on reset.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 forces the state to RESET_VAL immediately, independent of clk.
- tff_indata  input  WIDTH  toggle input T. Bit i = 1 means toggle bit i on the next enabled edge.
- tff_clr  input  1  synchronous clear; forces all bits to 0 on the next rising edge.
- tff_en  input  1  synchronous enable for toggling.
- tff_outdata  output  WIDTH  registered state Q.
- tff_outdata_bar  output  WIDTH  bitwise complement of tff_outdata (~Q).

Behaviour:
- State register q[WIDTH-1:0]. tff_outdata = q. tff_outdata_bar = ~q, purely combinational from q.
- Outputs never diverge from each other; they are never both 0 or both 1 on any bit.
- Reset:
  - While reset=0, q = RESET_VAL asynchronously, so tff_outdata_bar = ~RESET_VAL.
  - All other inputs are ignored while reset is low.
  - Deassertion (0->1) takes effect at the first rising edge after deassertion.
- Update at each rising clk edge with reset=1, first match wins:
  1. tff_clr=1: q <= 0. This happens regardless of tff_en and tff_indata.
  2. tff_en=0: q <= q (hold). tff_indata is ignored.
  3. tff_en=1: q <= q ^ tff_indata. Bits with T=0 hold; bits with T=1 invert.
- Latency: one clock. The new value is visible immediately after the rising edge and is stable for a full cycle.
- Continuous toggle: with tff_en=1 and T=1 held, the bit alternates every cycle, giving clk/2 frequency.
- Simultaneous events:
  - reset low overrides everything.
  - clr overrides en/toggle.
  - clr with en=0 still clears.
- Reset asserted mid-cycle: output changes immediately, with no wait for an edge.
- Inputs are sampled only at the rising edge; glitches between edges have no effect.
- No X propagation from q after reset. If an input is X at an edge, X may propagate only into the affected bits.

Optional Feature:
- Macro TFF_SYNC_SET_EN.
- Defined:
  - Adds input port tff_set (1 bit).
  - At a rising edge with reset=1, tff_set=1 forces q <= all ones.
  - Priority is reset > tff_clr > tff_set > enable/toggle.
- Undefined: the port does not exist, and behaviour is exactly as above.

Test Plan:
- Reset: after reset=0 and then reset=1, hold tff_en=0. Outputs stay tff_outdata=0 and tff_outdata_bar=1 across 5 edges.
- Toggle sequence (en=1):
  - T=1 for 1 edge gives out=1, bar=0.
  - Then T=0 for 1 edge holds out=1.
  - Then T=1 for 1 edge gives out=0, bar=1.
- Clear priority:
  - From out=1, set tff_clr=1 with en=1 and T=1. After one edge, out=0.
  - Repeat with en=0. After one edge, out=0.
- Enable gating:
  - en=0, T=1 for 3 edges: out holds its prior value (0 stays 0; 1 stays 1).
  - Then en=1, T=1 for 1 edge: out toggles.
- Async reset mid-cycle: with out=1, drive reset=0 between edges. out=0 and bar=1 before the next rising edge, and stay there while reset is low, even with en=1 and T=1.
- Complement invariant: randomized en/T/clr for 200 cycles. Check tff_outdata == ~tff_outdata_bar every cycle and q against a reference model. With TFF_SYNC_SET_EN, also check set=1 gives out=1 and clr+set gives out=0.
